// File: rtl/spi_master_tx_pkg.sv
// spi_master_tx_pkg: shared definitions for the SPI mode-0 transmitter.
//   - FSM state encoding
//   - RGBW command frame byte order and length
//   - SPI mode constants (CPOL=0, CPHA=0)
//   - max4(): sizes the shared phase counter from the timing parameters
package spi_master_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_BYTE_END = 3'd4,
    ST_HOLD     = 3'd5,
    ST_GAP      = 3'd6
  } state_e;

  // RGBW command frame layout (the transmitter itself is content-agnostic)
  localparam int IDX_MODE     = 0;
  localparam int IDX_LINT     = 1;
  localparam int IDX_RED      = 2;
  localparam int IDX_GREEN    = 3;
  localparam int IDX_BLUE     = 4;
  localparam int IDX_WHITE    = 5;
  localparam int IDX_COLORIDX = 6;
  localparam int FRAME_LEN    = 7;

  // SPI mode 0: sck idles low, receiver samples on the rising edge
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// spi_master_tx_if: byte stream in + SPI pins/status out of the transmitter.
//   tx_data/tx_valid/tx_last -> into transmitter, tx_ready <- back upstream
//   sck/mosi/cs              -> SPI bus (mode 0, cs active low)
//   busy/frame_done          -> frame status
// master modport: the transmitter. slave modport: the upstream/observer side.
interface spi_master_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       sck;
  logic       mosi;
  logic       cs;
  logic       busy;
  logic       frame_done;

  modport master (
    input  tx_data, tx_valid, tx_last,
    output tx_ready, sck, mosi, cs, busy, frame_done
  );

  modport slave (
    output tx_data, tx_valid, tx_last,
    input  tx_ready, sck, mosi, cs, busy, frame_done
  );
endinterface

// File: rtl/spi_master_tx_timer.sv
// spi_master_tx_timer: loadable down-counter shared by all timed phases.
//   clk, reset   : clock, synchronous active-low reset
//   load_i       : load load_val_i (phase length - 1) on state entry
//   load_val_i   : value to load
//   tc_o         : terminal count, high while the count is zero
// A phase of L cycles loads L-1, so tc_o is seen on the L-th cycle in the phase.
module spi_master_tx_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 master transmitter.
//   clk, reset : clock, synchronous active-low reset
//   bus        : spi_master_tx_if.master
//     tx_data/tx_valid/tx_last in, tx_ready out (combinational)
//     sck/mosi/cs, busy, frame_done out (registered)
// Bytes go out MSB first under one cs-low window per frame; tx_last closes
// the frame. Between bytes the block waits in BYTE_END (sck low, cs low)
// for as long as upstream takes to supply the next byte.
module spi_master_tx
  import spi_master_tx_pkg::*;
#(
  parameter int DIV_HALF  = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_master_tx_if.master bus
);

  localparam int CW = $clog2(max4(DIV_HALF, SETUP_CYC, HOLD_CYC, GAP_CYC) + 1);
  localparam logic [CW-1:0] LD_DIV   = CW'(DIV_HALF - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYC - 1);

  state_e        state_q, state_d;
  logic [6:0]    shreg_q, shreg_d;   // bits still to send after the one on mosi
  logic          last_q, last_d;
  logic [2:0]    bit_q, bit_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          cs_q, cs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tmr_load, tmr_tc;
  logic [CW-1:0] tmr_val;
  logic          tx_ready;
  logic          accept;

  spi_master_tx_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  assign tx_ready = ((state_q == ST_IDLE) || (state_q == ST_BYTE_END)) && reset;
  assign accept   = bus.tx_valid && tx_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d  = bus.tx_data[6:0];
          last_d   = bus.tx_last;
          bit_d    = 3'd0;
          mosi_d   = bus.tx_data[7];
          cs_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_SHIFT_LO;
          tmr_load = 1'b1;
          tmr_val  = LD_DIV;
        end
      end
      ST_SHIFT_LO: begin
        if (tmr_tc) begin
          sck_d    = 1'b1;
          state_d  = ST_SHIFT_HI;
          tmr_load = 1'b1;
          tmr_val  = LD_DIV;
        end
      end
      ST_SHIFT_HI: begin
        if (tmr_tc) begin
          sck_d = 1'b0;
          if (bit_q != 3'd7) begin
            // next bit goes out on the falling edge, a half period before the rise
            mosi_d   = shreg_q[6];
            shreg_d  = {shreg_q[5:0], 1'b0};
            bit_d    = bit_q + 3'd1;
            state_d  = ST_SHIFT_LO;
            tmr_load = 1'b1;
            tmr_val  = LD_DIV;
          end else begin
            state_d = ST_BYTE_END;
          end
        end
      end
      ST_BYTE_END: begin
        if (last_q) begin
          // frame is closing: a handshake here is deliberately dropped
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
        end else if (accept) begin
          shreg_d  = bus.tx_data[6:0];
          last_d   = bus.tx_last;
          bit_d    = 3'd0;
          mosi_d   = bus.tx_data[7];
          state_d  = ST_SHIFT_LO;
          tmr_load = 1'b1;
          tmr_val  = LD_DIV;
        end
      end
      ST_HOLD: begin
        if (tmr_tc) begin
          cs_d     = 1'b1;
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = LD_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_tc) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      last_q  <= 1'b0;
      bit_q   <= 3'd0;
      sck_q   <= SPI_CPOL;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_ready   = tx_ready;
  assign bus.sck        = sck_q;
  assign bus.mosi       = mosi_q;
  assign bus.cs         = cs_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: randomized + directed bench for spi_master_tx.
// The reference is a waveform queue: each accepted byte appends the exact
// per-cycle {sck,mosi,cs,busy,frame_done,tx_ready} it must produce, derived
// from the bit-time rules; an empty queue means "waiting" (in frame or idle).
// A loopback receiver rebuilds bytes on sck rises and matches them to the
// bytes handed over.
module tb_spi_master_tx;
  localparam int D = 2, S = 2, H = 2, G = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_tx_if bus();

  spi_master_tx #(.DIV_HALF(D), .SETUP_CYC(S), .HOLD_CYC(H), .GAP_CYC(G)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {logic sck, mosi, cs, busy, done, rdy, ign;} exp_t;
  typedef struct {logic [7:0] data; logic last; int dly;} stim_t;

  exp_t  wq[$];
  logic  frame_open = 1'b0, held = 1'b0;
  stim_t stim_q[$];
  stim_t cur;
  bit    have = 1'b0, rst_req = 1'b0;
  int    dly = 0;
  logic [7:0] sent_q[$];
  int    checks = 0, errors = 0, cyc = 0, acc_cyc = 0;

  logic prev_sck = 1'b0, prev_cs = 1'b1;
  logic [7:0] rx_sh = '0, last_rx = '0;
  int rx_bits = 0, rises = 0, dones = 0, cs_falls = 0, max_gap = 0, last_rise = -1;
  int first_rise_cyc = -1, last_fall_cyc = -1, cs_fall_cyc = -1, cs_rise_cyc = -1, min_high = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
    end
  endtask

  function automatic exp_t mk(input logic sck, mosi, cs, busy, done, rdy, ign);
    return '{sck, mosi, cs, busy, done, rdy, ign};
  endfunction

  task automatic push_n(input exp_t e, input int n);
    for (int i = 0; i < n; i++) wq.push_back(e);
  endtask

  // Waveform a byte must produce from the cycle after its accept edge.
  task automatic accept_byte(input logic [7:0] d, input logic last);
    if (!frame_open) push_n(mk(0, d[7], 0, 1, 0, 0, 0), S);
    for (int i = 7; i >= 0; i--) begin
      push_n(mk(0, d[i], 0, 1, 0, 0, 0), D);
      push_n(mk(1, d[i], 0, 1, 0, 0, 0), D);
    end
    if (last) begin
      push_n(mk(0, d[0], 0, 1, 0, 1, 1), 1);  // byte end, handshake ignored
      push_n(mk(0, d[0], 0, 1, 0, 0, 0), H);
      push_n(mk(0, d[0], 1, 1, 0, 0, 0), G);
      push_n(mk(0, d[0], 1, 0, 1, 1, 0), 1);  // frame_done, back to idle
    end
    frame_open = !last;
    sent_q.push_back(d);
  endtask

  task automatic monitor();
    if (bus.sck === 1'b1 && prev_sck === 1'b0) begin
      rises++;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
      if (last_rise >= 0 && cyc - last_rise > max_gap) max_gap = cyc - last_rise;
      last_rise = cyc;
      if (bus.cs === 1'b0) begin
        rx_sh = {rx_sh[6:0], bus.mosi};
        rx_bits++;
        if (rx_bits == 8) begin
          rx_bits = 0;
          last_rx = rx_sh;
          if (sent_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_byte got=0x%0h want=none", rx_sh);
          end else chk("rx_byte", rx_sh, sent_q.pop_front());
        end
      end
    end
    if (bus.sck === 1'b0 && prev_sck === 1'b1) last_fall_cyc = cyc;
    if (bus.cs === 1'b0 && prev_cs === 1'b1) begin
      cs_falls++;
      if (cs_rise_cyc >= 0 && (min_high == 0 || cyc - cs_rise_cyc < min_high)) min_high = cyc - cs_rise_cyc;
      cs_fall_cyc = cyc;
      rx_bits = 0;
    end
    if (bus.cs === 1'b1 && prev_cs === 1'b0) cs_rise_cyc = cyc;
    if (bus.frame_done === 1'b1) dones++;
    prev_sck = bus.sck;
    prev_cs  = bus.cs;
  endtask

  task automatic cycle();
    exp_t e;
    logic [5:0] got, want;
    @(negedge clk);
    cyc++;
    if (wq.size() > 0) e = wq.pop_front();
    else if (frame_open) e = mk(0, held, 0, 1, 0, 1, 0);
    else e = mk(0, held, 1, 0, 0, 1, 0);
    held = e.mosi;
    got  = {bus.sck, bus.mosi, bus.cs, bus.busy, bus.frame_done, bus.tx_ready};
    want = {e.sck, e.mosi, e.cs, e.busy, e.done, e.rdy & rst_n};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL cyc%0d {sck,mosi,cs,busy,done,rdy} got=%b want=%b", cyc, got, want);
    end
    monitor();
    rst_n = rst_req;
    if (!have && stim_q.size() > 0) begin
      cur = stim_q.pop_front(); dly = cur.dly; have = 1'b1;
    end
    if (have && dly == 0) begin
      bus.tx_valid = 1'b1; bus.tx_data = cur.data; bus.tx_last = cur.last;
    end else begin
      if (have) dly--;
      bus.tx_valid = 1'b0; bus.tx_data = 8'($urandom); bus.tx_last = 1'($urandom);
    end
    if (!rst_n) begin
      wq.delete(); frame_open = 1'b0; held = 1'b0; sent_q.delete(); rx_bits = 0;
    end else if (bus.tx_valid && e.rdy && !e.ign) begin
      accept_byte(cur.data, cur.last);
      have = 1'b0;
      acc_cyc = cyc;
    end
  endtask

  task automatic run_idle(input int budget, input string nm);
    int n = 0;
    while ((have || stim_q.size() > 0 || wq.size() > 0 || frame_open) && n < budget) begin
      cycle(); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout got=%0d cycles want<%0d", nm, n, budget);
    end
    cycle(); cycle();
  endtask

  task automatic clr_stats();
    rises = 0; dones = 0; cs_falls = 0; max_gap = 0; last_rise = -1;
    first_rise_cyc = -1; last_fall_cyc = -1; cs_rise_cyc = -1; min_high = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic l, input int w);
    stim_t s;
    s.data = d; s.last = l; s.dly = w;
    stim_q.push_back(s);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rgbw [7];
    int n, nf;
    rgbw = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h10};
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.tx_last = 1'b0;

    // reset held 5 cycles
    @(posedge clk);
    repeat (5) cycle();
    chk("rst_cs", bus.cs, 1);
    chk("rst_sck", bus.sck, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_ready", bus.tx_ready, 0);
    chk("rst_busy", bus.busy, 0);
    rst_req = 1'b1;
    cycle(); cycle();
    chk("ready_after_rst", bus.tx_ready, 1);

    // single byte 0xA5
    clr_stats();
    push(8'hA5, 1'b1, 0);
    run_idle(300, "single");
    chk("single_cs_fall_lat", cs_fall_cyc - acc_cyc, 1);
    chk("single_first_rise", first_rise_cyc - cs_fall_cyc, 4);
    chk("single_rises", rises, 8);
    chk("single_bit_period", max_gap, 4);
    chk("single_rx", last_rx, 8'hA5);
    chk("single_cs_hold", cs_rise_cyc - last_fall_cyc, 3);  // byte-end cycle + HOLD_CYC
    chk("single_dones", dones, 1);

    // full RGBW frame back to back
    clr_stats();
    for (int i = 0; i < 7; i++) push(rgbw[i], i == 6, 0);
    run_idle(1000, "rgbw");
    chk("rgbw_rises", rises, 56);
    chk("rgbw_frames", cs_falls, 1);
    chk("rgbw_max_gap", max_gap, 5);  // one extra sck-low cycle between bytes
    chk("rgbw_all_rx", sent_q.size(), 0);
    chk("rgbw_dones", dones, 1);

    // underrun: byte 2 withheld 50 cycles
    clr_stats();
    push(8'h12, 1'b0, 0); push(8'h34, 1'b0, 50); push(8'hC7, 1'b1, 0);
    run_idle(1000, "underrun");
    chk("under_frames", cs_falls, 1);
    chk("under_rises", rises, 24);
    chk("under_all_rx", sent_q.size(), 0);
    chk("under_dones", dones, 1);

    // back-to-back single-byte frames, valid held high
    clr_stats();
    push(8'hC3, 1'b1, 0); push(8'h96, 1'b1, 0);
    run_idle(1000, "b2b");
    chk("b2b_frames", cs_falls, 2);
    chk("b2b_dones", dones, 2);
    chk("b2b_cs_high", min_high, G + 1);
    chk("b2b_rx", last_rx, 8'h96);

    // reset after 3 sck rises of a byte
    clr_stats();
    push(8'h5A, 1'b0, 0);
    n = 0;
    while (rises < 3 && n < 300) begin cycle(); n++; end
    chk("midrst_reach", rises >= 3, 1);
    rst_req = 1'b0; cycle();
    rst_req = 1'b1; cycle();
    chk("midrst_cs", bus.cs, 1);
    chk("midrst_sck", bus.sck, 0);
    push(8'h3C, 1'b1, 0);
    run_idle(500, "midrst");
    chk("midrst_dones", dones, 1);
    chk("midrst_rx", last_rx, 8'h3C);

    // randomized frames
    clr_stats();
    nf = 25;
    for (int f = 0; f < nf; f++) begin
      n = $urandom_range(1, 7);
      for (int b = 0; b < n; b++)
        push(8'($urandom), b == n - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0);
    end
    run_idle(30000, "random");
    chk("rand_all_rx", sent_q.size(), 0);
    chk("rand_frames", cs_falls, nf);
    chk("rand_dones", dones, nf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
